// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: instruction format codes, base opcodes and the
// signed immediate ranges each format can represent.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -1048576;
  localparam int IMMJ_MAX  = 1048574;

  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO holding encoded words; reports full/empty and presents the head.
module enc_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is not reset; empty gates every use of the head entry.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      if (do_push && !do_pop)      count <= count + 2'd1;
      else if (!do_push && do_pop) count <= count - 2'd1;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: combinational field packing and immediate range
// checks, buffered through a 2-entry FIFO with encode/error statistics.
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
);

  logic [31:0] word;
  logic        err;
  logic [32:0] head;
  logic        full;
  logic        empty;
  logic        ready_q;
  logic        pop;

  // Erroneous entries still carry the truncated fields; only reserved formats zero the word.
  always_comb begin
    word = 32'h0;
    err  = 1'b0;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
        err  = !in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = !in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = !in_range(imm, IMMB_MIN, IMMB_MAX) || imm[0];
      end
      FMT_U: begin
        word = {imm[31:12], rd, opcode};
        err  = (imm[11:0] != 12'h0);
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = !in_range(imm, IMMJ_MIN, IMMJ_MAX) || imm[0];
      end
      default: begin
        word = 32'h0;
        err  = 1'b1;
      end
    endcase
  end

  // Holds in_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  assign in_ready  = ready_q && !full;
  assign out_valid = !empty;
  assign out_instr = out_valid ? head[31:0] : 32'h0;
  assign out_err   = out_valid ? head[32] : 1'b0;
  assign pop       = out_valid && out_ready;

  enc_fifo2 #(.WIDTH(33)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .wdata ({err, word}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_count <= 16'h0;
      err_count <= 16'h0;
    end else if (pop) begin
      enc_count <= enc_count + 16'h1;
      if (out_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'h1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder with hand-computed expected words.
module tb_instr_encoder;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count, err_count;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] got [3];

  instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setInputs(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic waitAccept();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                               input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] im);
    setInputs(f, op, d, s1, s2, f3, f7, im);
    waitAccept();
  endtask

  task automatic popCheck(input string tag, input logic [31:0] exp_instr, input logic exp_err);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, "_instr"}, out_instr, exp_instr);
    checkOutput({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    setInputs(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    #12;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'h0);
    checkOutput("rst_counts", {enc_count, err_count}, 32'h0);
    @(negedge clk); rst = 1'b0;
    #1 checkOutput("post_rst_not_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("post_rst_ready", {31'd0, in_ready}, 32'd1);

    applyStimulus(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    popCheck("i_neg1", 32'hFFF00093, 1'b0);
    checkOutput("enc_count_1", {16'd0, enc_count}, 32'd1);

    applyStimulus(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    popCheck("b_8", 32'h00208463, 1'b0);
    applyStimulus(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    popCheck("j_2048", 32'h001000EF, 1'b0);
    applyStimulus(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    popCheck("u_lui", 32'h123452B7, 1'b0);
    applyStimulus(FMT_R, OP_REG, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0);
    popCheck("r_sub", 32'h403100B3, 1'b0);
    applyStimulus(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047);
    popCheck("i_max", 32'h7FF00093, 1'b0);
    applyStimulus(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFF000);
    popCheck("b_min", 32'h80208063, 1'b0);
    checkOutput("err_count_0", {16'd0, err_count}, 32'd0);

    applyStimulus(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    popCheck("i_oor", 32'h80000093, 1'b1);
    checkOutput("err_count_1", {16'd0, err_count}, 32'd1);
    applyStimulus(FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    popCheck("b_odd", 32'h00208163, 1'b1);
    checkOutput("err_count_2", {16'd0, err_count}, 32'd2);
    applyStimulus(3'd6, OP_REG, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    popCheck("reserved", 32'h0, 1'b1);
    checkOutput("err_count_3", {16'd0, err_count}, 32'd3);
    checkOutput("enc_count_10", {16'd0, enc_count}, 32'd10);

    // Backpressure: two accepts fill the FIFO, the third waits for space.
    applyStimulus(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    applyStimulus(FMT_I, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    setInputs(FMT_I, OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_hold", out_instr, 32'h00100093);
    out_ready = 1'b1;
    fork
      waitAccept();
      begin
        for (int k = 0; k < 3; k++) begin
          int n = 0;
          @(negedge clk);
          while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
          end
          got[k] = out_instr;
          @(posedge clk);
        end
      end
    join
    #1 out_ready = 1'b0;
    checkOutput("bp_word0", got[0], 32'h00100093);
    checkOutput("bp_word1", got[1], 32'h00200113);
    checkOutput("bp_word2", got[2], 32'h00300193);
    checkOutput("bp_enc_count", {16'd0, enc_count}, 32'd13);
    checkOutput("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset while full discards both entries.
    applyStimulus(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    applyStimulus(FMT_I, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_counts", {enc_count, err_count}, 32'h0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_ready_back", {31'd0, in_ready}, 32'd1);
    applyStimulus(FMT_I, OP_IMM, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    popCheck("after_rst", 32'h00500293, 1'b0);
    checkOutput("after_rst_enc", {16'd0, enc_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have one clock and one reset: the clock is rising-edge; the reset is asynchronous and active-high.
REQ-002 SHALL have port `clk`, input, 1 bit: system clock.
REQ-003 SHALL have port `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port `in_valid`, input, 1 bit: an encode request is present.
REQ-005 SHALL have port `in_ready`, output, 1 bit: the block accepts a request this cycle.
REQ-006 SHALL have port `fmt`, input, 3 bits: format select, with R=0, I=1, S=2, B=3, U=4, J=5, and 6-7 reserved.
REQ-007 SHALL have port `opcode`, input, 7 bits: placed into bits [6:0] unchanged.
REQ-008 SHALL have ports `rd`, `rs1` and `rs2`, input, 5 bits each: register fields.
REQ-009 SHALL have ports `funct3` (input, 3 bits) and `funct7` (input, 7 bits).
REQ-010 SHALL have port `imm`, input, 32 bits: signed immediate as a byte offset; for U format it is the full 32-bit value.
REQ-011 SHALL have ports `out_valid` (output, 1 bit), `out_ready` (input, 1 bit), `out_instr` (output, 32 bits) and `out_err` (output, 1 bit).
REQ-012 SHALL have ports `enc_count` and `err_count`, output, 16 bits each: statistics counters.

Function
REQ-013 SHALL treat a request as accepted when `in_valid` and `in_ready` are both high at a rising edge.
REQ-014 SHALL encode per format:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
REQ-015 SHALL raise the error flag for an entry when the immediate is out of range for its format:
  - I and S: not in [-2048, 2047].
  - B: not in [-4096, 4094], or imm[0]=1.
  - J: not in [-1048576, 1048574], or imm[0]=1.
  - U: imm[11:0] != 0.
  - Reserved fmt: always an error, with the word = 32'h0.
  - R: never an error.
REQ-016 SHALL still emit an erroneous entry, with truncated fields per REQ-014 and `out_err`=1.
REQ-017 SHALL register the encoded word and error flag into a 2-entry FIFO on acceptance; an entry accepted at edge N is visible on the output from cycle N+1 at the earliest.
REQ-018 SHALL drive `in_ready` = (FIFO occupancy < 2), with no combinational path from `out_ready`.
REQ-019 SHALL pop the head on `out_valid` && `out_ready`; `out_valid` = (occupancy > 0).
REQ-020 SHALL hold `out_instr` and `out_err` stable while `out_valid`=1 and `out_ready`=0.
REQ-021 SHALL handle a simultaneous push and pop at occupancy 1 by leaving occupancy at 1, preserving order and losing no data.
REQ-022 SHALL ignore a pop when empty and a push when full (the latter is impossible by REQ-018).
REQ-023 SHALL increment `enc_count` by 1 on every pop, wrapping from 16'hFFFF to 0.
REQ-024 SHALL increment `err_count` on every pop where `out_err`=1, saturating at 16'hFFFF.
REQ-025 SHALL ensure that any error-free word fed to the team's immediate generator returns the original `imm`.

Reset
REQ-026 SHALL, while `rst`=1, asynchronously clear the FIFO pointers, occupancy, `enc_count` and `err_count` to 0.
REQ-027 SHALL, during reset, drive `out_valid`=0, `in_ready`=0, and `out_instr`=0, `out_err`=0.
REQ-028 SHALL, on reset mid-operation, discard all FIFO contents; `in_ready` rises on the first edge after `rst` deasserts.

Structure
REQ-029 SHALL take the format enumeration, the RV32I opcode constants and the immediate range limits from the shared package `riscv_pkg`.
REQ-030 SHALL place the 2-entry FIFO in sub-module `enc_fifo2`, 33 bits wide (word plus error flag); encoding and range checks are combinational in `instr_encoder`.

Verification
REQ-031 SHALL cover an I-type encode: fmt=I, opcode=7'h13, rd=1, rs1=0, funct3=0, imm=-1 -> `out_instr`=32'hFFF00093, `out_err`=0, `enc_count`=1.
REQ-032 SHALL cover a B-type encode: fmt=B, opcode=7'h63, rs1=1, rs2=2, funct3=0, imm=8 -> 32'h00208463.
REQ-033 SHALL cover J-type and U-type encodes:
  - fmt=J, opcode=7'h6F, rd=1, imm=2048 -> 32'h001000EF.
  - fmt=U, opcode=7'h37, rd=5, imm=32'h12345000 -> 32'h123452B7.
REQ-034 SHALL cover an out-of-range immediate: fmt=I, imm=2048 -> `out_err`=1 with word imm field 12'h800, `err_count`=1; then fmt=B, imm=3 -> `out_err`=1, `err_count`=2.
REQ-035 SHALL cover backpressure: `out_ready`=0, three back-to-back requests -> `in_ready`=0 after two accepts, `out_instr` stable; release `out_ready` -> all three emerge in order, `enc_count`=3.
REQ-036 SHALL cover reset mid-operation: assert `rst` with occupancy 2 -> `out_valid`=0 immediately, both counters=0; after release, a new request is the first word out.
